// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
// Forward-select encoding, divider FSM states and the forward priority picker.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  // M is the younger producer, so it beats W
  function automatic fwd_sel_t fwd_pick(
    input logic hit_m,
    input logic hit_w
  );
    if (hit_m) return FWD_M;
    if (hit_w) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: datapath <-> hazard unit signal bundle.
// master = datapath side, slave = hazard controller side.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] rsD, rtD;
  logic              branchD, jrD;
  logic [REG_AW-1:0] rsE, rtE, writeregE;
  logic              regwriteE, memtoregE, div_startE;
  logic [REG_AW-1:0] writeregM;
  logic              regwriteM, memtoregM;
  logic [REG_AW-1:0] writeregW;
  logic              regwriteW;
  logic              excM, eretM;

  logic              stallF, stallD, stallE;
  logic              flushD, flushE, flushM;
  logic [1:0]        forwardaD, forwardbD;
  logic [1:0]        forwardaE, forwardbE;
  logic              div_busy, div_doneE;
  logic [CNT_W-1:0]  stall_cnt, load_stall_cnt, div_stall_cnt;

  modport master (
    output rsD, rtD, branchD, jrD,
    output rsE, rtE, writeregE,
    output regwriteE, memtoregE, div_startE,
    output writeregM, regwriteM, memtoregM,
    output writeregW, regwriteW, excM, eretM,
    input  stallF, stallD, stallE,
    input  flushD, flushE, flushM,
    input  forwardaD, forwardbD,
    input  forwardaE, forwardbE,
    input  div_busy, div_doneE,
    input  stall_cnt, load_stall_cnt, div_stall_cnt
  );

  modport slave (
    input  rsD, rtD, branchD, jrD,
    input  rsE, rtE, writeregE,
    input  regwriteE, memtoregE, div_startE,
    input  writeregM, regwriteM, memtoregM,
    input  writeregW, regwriteW, excM, eretM,
    output stallF, stallD, stallE,
    output flushD, flushE, flushM,
    output forwardaD, forwardbD,
    output forwardaE, forwardbE,
    output div_busy, div_doneE,
    output stall_cnt, load_stall_cnt, div_stall_cnt
  );
endinterface

// File: rtl/hazard_div_fsm.sv
// hazard_div_fsm: multi-cycle divider occupancy tracker.
// Stalls E for DIV_CYCLES cycles including the start cycle.
module hazard_div_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic abort,
  output logic stall,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  div_state_t      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (start) begin
          r_state <= BUSY;
          r_cnt   <= LOAD;
          r_busy  <= 1'b1;
        end
        BUSY: begin
          r_cnt <= r_cnt - ONE;
          if (r_cnt == ONE) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // resetn gate drops the start-cycle stall while reset is held
  assign stall = resetn & ((r_state == IDLE & start) | r_busy);
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to build the stall performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input logic         clk,
  input logic         resetn,
  hazard_ctrl_if.slave h
);
  function automatic logic hit(
    input logic              we,
    input logic [REG_AW-1:0] dst,
    input logic [REG_AW-1:0] src
  );
    return we && (dst != '0) && (dst == src);
  endfunction

  logic w_exc, w_load, w_branch, w_div, w_hold;

  assign w_exc  = h.excM | h.eretM;
  assign w_load = hit(h.memtoregE & h.regwriteE, h.writeregE, h.rsD)
                | hit(h.memtoregE & h.regwriteE, h.writeregE, h.rtD);

  assign w_branch = (h.branchD | h.jrD)
    & ( hit(h.regwriteE, h.writeregE, h.rsD)
      | hit(h.regwriteE, h.writeregE, h.rtD)
      | hit(h.memtoregM, h.writeregM, h.rsD)
      | hit(h.memtoregM, h.writeregM, h.rtD));

  hazard_div_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk    (clk),
    .resetn (resetn),
    .start  (h.div_startE),
    .abort  (w_exc),
    .stall  (w_div),
    .busy   (h.div_busy),
    .done   (h.div_doneE)
  );

  // exceptions override every stall so the flush can take effect
  assign w_hold   = resetn & ~w_exc;
  assign h.stallF = w_hold & (w_load | w_branch | w_div);
  assign h.stallD = h.stallF;
  assign h.stallE = w_hold & w_div;
  assign h.flushD = resetn & w_exc;
  assign h.flushM = resetn & w_exc;
  assign h.flushE = resetn & (w_exc | ((w_load | w_branch) & ~w_div));

  assign h.forwardaD = resetn ? fwd_pick(
    hit(h.regwriteM, h.writeregM, h.rsD),
    hit(h.regwriteW, h.writeregW, h.rsD)) : FWD_RF;
  assign h.forwardbD = resetn ? fwd_pick(
    hit(h.regwriteM, h.writeregM, h.rtD),
    hit(h.regwriteW, h.writeregW, h.rtD)) : FWD_RF;
  assign h.forwardaE = resetn ? fwd_pick(
    hit(h.regwriteM, h.writeregM, h.rsE),
    hit(h.regwriteW, h.writeregW, h.rsE)) : FWD_RF;
  assign h.forwardbE = resetn ? fwd_pick(
    hit(h.regwriteM, h.writeregM, h.rtE),
    hit(h.regwriteW, h.writeregW, h.rtE)) : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_load_cnt, r_div_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
      r_load_cnt  <= '0;
      r_div_cnt   <= '0;
    end else begin
      if (h.stallF) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_load)   r_load_cnt  <= r_load_cnt + 1'b1;
      if (w_div)    r_div_cnt   <= r_div_cnt + 1'b1;
    end
  end

  assign h.stall_cnt      = r_stall_cnt;
  assign h.load_stall_cnt = r_load_cnt;
  assign h.div_stall_cnt  = r_div_cnt;
`else
  assign h.stall_cnt      = {CNT_W{1'b0}};
  assign h.load_stall_cnt = {CNT_W{1'b0}};
  assign h.div_stall_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stalls, divider and abort.
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hif ();

  hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(32), .CNT_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .h      (hif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hif.rsD = '0; hif.rtD = '0; hif.branchD = 0; hif.jrD = 0;
    hif.rsE = '0; hif.rtE = '0; hif.writeregE = '0;
    hif.regwriteE = 0; hif.memtoregE = 0; hif.div_startE = 0;
    hif.writeregM = '0; hif.regwriteM = 0; hif.memtoregM = 0;
    hif.writeregW = '0; hif.regwriteW = 0;
    hif.excM = 0; hif.eretM = 0;
  endtask

  logic [31:0] e_stall, e_load, e_div;

  initial begin
`ifdef HAZARD_PERF_CNT_EN
    e_stall = 33; e_load = 1; e_div = 32;
`else
    e_stall = 0; e_load = 0; e_div = 0;
`endif
    clr();
    #1;
    chk("rst_stallF", hif.stallF, 0);
    chk("rst_flushE", hif.flushE, 0);
    chk("rst_busy", hif.div_busy, 0);
    chk("rst_done", hif.div_doneE, 0);
    chk("rst_cnt", hif.stall_cnt, 0);
    @(negedge clk);
    resetn = 1;
    @(negedge clk);

    hif.rsE = 8; hif.rtE = 8;
    hif.writeregM = 8; hif.regwriteM = 1;
    hif.writeregW = 8; hif.regwriteW = 1;
    #1;
    chk("fwdaE_M", hif.forwardaE, 2'b10);
    chk("fwdbE_M", hif.forwardbE, 2'b10);
    hif.regwriteM = 0; #1;
    chk("fwdaE_W", hif.forwardaE, 2'b01);
    hif.regwriteM = 1; hif.rsE = 0; #1;
    chk("fwdaE_r0", hif.forwardaE, 2'b00);
    chk("fwdbE_M2", hif.forwardbE, 2'b10);
    hif.rsD = 8; hif.rtD = 3; #1;
    chk("fwdaD_M", hif.forwardaD, 2'b10);
    chk("fwdbD_rf", hif.forwardbD, 2'b00);
    clr();
    @(negedge clk);

    hif.memtoregE = 1; hif.regwriteE = 1;
    hif.writeregE = 9; hif.rtD = 9;
    #1;
    chk("ld_stallF", hif.stallF, 1);
    chk("ld_stallD", hif.stallD, 1);
    chk("ld_flushE", hif.flushE, 1);
    chk("ld_stallE", hif.stallE, 0);
    @(negedge clk);
    hif.regwriteE = 0; #1;
    chk("ld_nowe_stallF", hif.stallF, 0);
    chk("ld_nowe_flushE", hif.flushE, 0);
    clr();
    @(negedge clk);

    hif.branchD = 1; hif.rsD = 4;
    hif.memtoregM = 1; hif.writeregM = 4;
    #1;
    chk("br_stallD", hif.stallD, 1);
    chk("br_flushE", hif.flushE, 1);
    #1 clr();
    #1;
    chk("br_clear", hif.stallD, 0);
    @(negedge clk);

    hif.div_startE = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("div_stallE_%0d", i), hif.stallE, 1);
      chk($sformatf("div_done_%0d", i), hif.div_doneE, 0);
      @(negedge clk);
    end
    #1;
    chk("div_end_stallE", hif.stallE, 0);
    chk("div_end_stallF", hif.stallF, 0);
    chk("div_doneE", hif.div_doneE, 1);
    chk("div_end_busy", hif.div_busy, 0);
    chk("cnt_stall", hif.stall_cnt, e_stall);
    chk("cnt_load", hif.load_stall_cnt, e_load);
    chk("cnt_div", hif.div_stall_cnt, e_div);
    @(negedge clk);
    #1;
    chk("after_done_busy", hif.div_busy, 0);
    chk("after_done_done", hif.div_doneE, 0);
    chk("b2b_stallE", hif.stallE, 1);
    hif.div_startE = 0; #1;
    chk("idle_stallE", hif.stallE, 0);
    @(negedge clk);

    hif.div_startE = 1;
    repeat (5) @(negedge clk);
    hif.div_startE = 0;
    hif.excM = 1;
    #1;
    chk("exc_busy", hif.div_busy, 1);
    chk("exc_flushD", hif.flushD, 1);
    chk("exc_flushE", hif.flushE, 1);
    chk("exc_flushM", hif.flushM, 1);
    chk("exc_stallF", hif.stallF, 0);
    chk("exc_stallE", hif.stallE, 0);
    @(negedge clk);
    hif.excM = 0; #1;
    chk("exc_idle_busy", hif.div_busy, 0);
    chk("exc_idle_stallE", hif.stallE, 0);
    chk("exc_flushM_off", hif.flushM, 0);

    @(negedge clk);
    hif.div_startE = 1;
    repeat (3) @(negedge clk);
    hif.rsE = 8; hif.writeregM = 8; hif.regwriteM = 1;
    #1;
    chk("pre_rst_stallE", hif.stallE, 1);
    chk("pre_rst_fwd", hif.forwardaE, 2'b10);
    resetn = 0; #1;
    chk("arst_stallE", hif.stallE, 0);
    chk("arst_stallF", hif.stallF, 0);
    chk("arst_busy", hif.div_busy, 0);
    chk("arst_fwd", hif.forwardaE, 0);
    chk("arst_cnt", hif.div_stall_cnt, 0);
    hif.div_startE = 0;
    @(negedge clk);
    resetn = 1; #1;
    chk("post_rst_busy", hif.div_busy, 0);
    chk("post_rst_stallE", hif.stallE, 0);
    clr();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting beside the datapath and driving all stall, flush and forward-select signals. Adds to the previous-generation unit: a configurable register-address width, an internal multi-cycle divider occupancy FSM, exception/ERET flush sequencing from M, M-stage load checks gated by the write register, and optional stall performance counters.

## Interface
- REG_AW, 5, register-file address width
- DIV_CYCLES, 32, total E-stage stall cycles per divide; must be ≥ 2
- CNT_W, 32, performance counter width
- clk  in  1  core clock, rising edge
- resetn  in  1  reset, asynchronous assert, active-low
- rsD, rtD  in  REG_AW  D-stage source registers
- branchD, jrD  in  1  D-stage instruction resolves a branch/jr in D
- rsE, rtE, writeregE  in  REG_AW  E-stage sources, destination
- regwriteE, memtoregE  in  1  E-stage write enable, load
- div_startE  in  1  E-stage holds a div/divu
- writeregM  in  REG_AW; regwriteM, memtoregM  in  1  M-stage destination, write enable, load
- writeregW  in  REG_AW; regwriteW  in  1  W-stage destination, write enable
- excM, eretM  in  1  exception taken / eret committing in M
- stallF, stallD, stallE  out  1  hold stage registers
- flushD, flushE, flushM  out  1  clear stage registers to bubble
- forwardaD, forwardbD  out  2  D-compare operand select
- forwardaE, forwardbE  out  2  E ALU operand select
- div_busy  out  1  divider occupied (BUSY state)
- div_doneE  out  1  divide result valid this cycle
- stall_cnt, load_stall_cnt, div_stall_cnt  out  CNT_W  performance counters

## Operation
- Forward encoding: 00 register file, 01 from W, 10 from M. M wins over W. Register 0 never forwards. Applies to both D and E selects.
- loadstall = memtoregE & regwriteE & writeregE≠0 & (writeregE==rsD | writeregE==rtD).
- branchstall = (branchD|jrD) & ((regwriteE & writeregE≠0 & writeregE∈{rsD,rtD}) | (memtoregM & writeregM≠0 & writeregM∈{rsD,rtD})).
- Divider FSM states IDLE, BUSY, DONE; counter width $clog2(DIV_CYCLES).
  - IDLE: div_startE=1 → BUSY, counter ← DIV_CYCLES−1.
  - BUSY: counter decrements each cycle; counter==1 → DONE.
  - DONE: one cycle, div_doneE=1 → IDLE. div_startE is ignored in DONE.
- divstall = (IDLE & div_startE) | BUSY.
- Stall and flush outputs:
  - stallF = stallD = loadstall | branchstall | divstall.
  - stallE = divstall.
  - flushE = (loadstall | branchstall) & ~divstall.
- Exception priority: excM | eretM forces flushD = flushE = flushM = 1 and all stalls to 0 in that cycle. The FSM returns to IDLE at the next edge from any state.

## Timing
- Forward, stall and flush outputs are combinational, with zero-cycle latency from inputs.
- A divide stalls E for exactly DIV_CYCLES cycles, counting the div_startE cycle. div_doneE is asserted in the following cycle.
- Back-to-back divides: a second div_startE in the cycle after DONE starts a new sequence.
- Reset value of every output is 0. FSM resets to IDLE, counter to 0.
- Reset asserted mid-divide: FSM → IDLE immediately and divstall drops asynchronously.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle with stallF=1.
  - load_stall_cnt increments on loadstall.
  - div_stall_cnt increments on divstall.
  - All counters wrap modulo 2^CNT_W and reset to 0.
- HAZARD_PERF_CNT_EN undefined: counter outputs are tied to 0 and no counter flops exist.

## Structure
- hazard_pkg holds:
  - fwd_sel_t with FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - div_state_t with IDLE, BUSY, DONE.
- Sub-module hazard_div_fsm holds the FSM and counter. Inputs: clk, resetn, start, abort. Outputs: stall, busy, done.

## Test plan
- Forwarding: rsE=rtE=8, writeregM=8/regwriteM=1, writeregW=8/regwriteW=1 → forwardaE=forwardbE=10. With rsE=0 under the same conditions → forwardaE=00.
- Load-use: memtoregE=1, regwriteE=1, writeregE=9, rtD=9 → stallF=stallD=flushE=1 for 1 cycle. The same case with regwriteE=0 → no stall.
- Branch: branchD=1, rsD=4, memtoregM=1, writeregM=4 → stallD=1 and flushE=1.
- Divide, DIV_CYCLES=32: div_startE held high → stallE=1 for exactly 32 cycles, then div_doneE=1 for 1 cycle, then div_startE is ignored in DONE.
- Abort: excM pulses in BUSY cycle 5 → flushD/E/M=1 and stalls=0 that cycle, then FSM is IDLE next cycle. Repeat the case with resetn dropped mid-BUSY → all outputs 0 asynchronously.
- Perf counters with HAZARD_PERF_CNT_EN: one load stall plus one 32-cycle divide → stall_cnt=33, load_stall_cnt=1, div_stall_cnt=32. With the macro undefined, all three counters read 0.
